collatz_sweep_ctrl: RTL and testbench
=====================================

Name: collatz_sweep_ctrl

Overview:
Sequencer that drives the Collatz engine (co/st/k interface) over an inclusive range of start values [lo, hi]. It launches one run per value, waits for completion, and records the start value with the largest step count. It sits between the top-level control inputs and the existing Collatz datapath/FSM pair, and owns the engine's co and st inputs.

Parameters:
W_CO, 16, width of start values (matches engine co/x)
W_K, 20, width of step count (matches engine k)
TIMEOUT, 1048575, max cycles to wait for eng_done per run before aborting

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
go  in  1  start sweep; sampled in IDLE only
lo  in  W_CO  first start value, captured on accepted go
hi  in  W_CO  last start value (inclusive), captured on accepted go
eng_co  out  W_CO  start value presented to engine, stable from launch until eng_done
eng_st  out  1  one-cycle launch pulse to engine
eng_done  in  1  one-cycle pulse from engine: run finished, eng_k valid this cycle
eng_k  in  W_K  step count of finished run
busy  out  1  high from accepted go until FINISH
done  out  1  level; high after sweep ends, cleared on next accepted go
err  out  1  level; sweep aborted (bad range or timeout), valid while done
best_co  out  W_CO  start value with largest k so far
best_k  out  W_K  largest k so far
cur  out  W_CO  start value currently being processed

Behaviour:
- Reset (async, any state): state=IDLE; eng_co, eng_st, busy, done, err, best_co, best_k, cur, timer all 0.
- States: IDLE, LAUNCH, WAIT, UPDATE, FINISH.
- IDLE: on go=1: capture lo/hi; clear done, err, best_co, best_k; busy<=1. If lo==0 or lo>hi -> FINISH with err<=1 (0 never terminates in the engine). Else cur<=lo -> LAUNCH.
- LAUNCH (1 cycle): eng_co<=cur, eng_st<=1 for exactly this one cycle; timer<=0 -> WAIT.
- WAIT: eng_st=0, eng_co held. On eng_done: latch eng_k -> UPDATE. Else timer++; if timer reaches TIMEOUT-1 -> FINISH with err<=1 (best_* keep values of completed runs).
- UPDATE (1 cycle): if latched k > best_k (strict): best_k<=k, best_co<=cur. Ties keep the earlier (smaller) co. Then if cur==hi -> FINISH; else cur<=cur+1 -> LAUNCH. The cur==hi comparison precedes the increment, so hi=2^W_CO-1 terminates without wrap.
- FINISH (1 cycle): busy<=0, done<=1 -> IDLE.
- Per-value overhead: LAUNCH + UPDATE = 2 cycles beyond engine latency. Sweep of N values ends N*(L+2)+1 cycles after go, where L is the cycles from eng_st to eng_done.
- go while busy: ignored. eng_done outside WAIT: ignored. eng_done in the same cycle as the timeout boundary: eng_done wins.
- go is level-sampled: if go is still high in the cycle after FINISH, a new sweep starts. Callers pulse go.
- Reset mid-sweep: all results lost and eng_st drops immediately. The engine itself is not reset by this block.
- All counters are unsigned. best_k starts at 0, so the first completed run always updates (including k=0 for co=1).

Decomposition:
- Shared package collatz_pkg: W_CO, W_K, and the state enum typedef (IDLE..FINISH), also reused by the engine FSM.
- No sub-module needed. The timeout counter is inline; at most a trivial counter helper.

Test Plan:
- lo=1, hi=10 with the real engine -> done=1, err=0, best_co=9, best_k=19; exactly 10 eng_st pulses with eng_co=1..10.
- lo=27, hi=27 -> one launch; best_co=27, best_k=111; busy falls one cycle after UPDATE.
- lo=5, hi=3 and lo=0, hi=4 -> FINISH two cycles after go, err=1, no eng_st pulse, best_k=0.
- Stub engine never returns eng_done, TIMEOUT=8 -> err=1 and done=1 exactly 8 WAIT cycles after launch.
- Tie check with stub returning k=7 for co=10,11 -> best_co=10. Also lo=hi=65535 with a stub -> a single run, no wrap to 0.
- Assert rst for one cycle mid-WAIT on lo=1, hi=100 -> all outputs 0 asynchronously; a subsequent go with lo=6, hi=6 gives best_k=8.

Source files
------------

// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz engine and its sweep sequencer.
package collatz_pkg;

    localparam int W_CO = 16;
    localparam int W_K  = 20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        UPDATE = 3'd3,
        FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/collatz_sweep_ctrl.sv
// Sweeps the Collatz engine over an inclusive range of start values and keeps
// the start value that produced the largest step count. Ties keep the earliest.
module collatz_sweep_ctrl #(
    parameter int W_CO    = collatz_pkg::W_CO,
    parameter int W_K     = collatz_pkg::W_K,
    parameter int TIMEOUT = 1048575
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [W_CO-1:0] lo,
    input  logic [W_CO-1:0] hi,
    output logic [W_CO-1:0] eng_co,
    output logic            eng_st,
    input  logic            eng_done,
    input  logic [W_K-1:0]  eng_k,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [W_CO-1:0] best_co,
    output logic [W_K-1:0]  best_k,
    output logic [W_CO-1:0] cur
);
    import collatz_pkg::*;

    // Timer only has to count 0..TIMEOUT-1.
    localparam int W_T = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W_T-1:0] TIMER_LAST = W_T'(TIMEOUT - 1);

    state_t          state_q;
    logic [W_CO-1:0] hi_q;
    logic [W_CO-1:0] cur_q;
    logic [W_CO-1:0] eng_co_q;
    logic            eng_st_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [W_CO-1:0] best_co_q;
    logic [W_K-1:0]  best_k_q;
    logic [W_K-1:0]  k_q;
    logic [W_T-1:0]  timer_q;

    // Sweep sequencer: all outputs registered, one run per start value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            cur_q     <= '0;
            eng_co_q  <= '0;
            eng_st_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            best_co_q <= '0;
            best_k_q  <= '0;
            k_q       <= '0;
            timer_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        hi_q      <= hi;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        best_co_q <= '0;
                        best_k_q  <= '0;
                        busy_q    <= 1'b1;
                        // Zero never terminates in the engine, and an empty
                        // range has nothing to run.
                        if ((lo == '0) || (lo > hi)) begin
                            err_q   <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            cur_q   <= lo;
                            state_q <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    eng_co_q <= cur_q;
                    eng_st_q <= 1'b1;
                    timer_q  <= '0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    eng_st_q <= 1'b0;
                    // A completion arriving on the timeout boundary still counts.
                    if (eng_done) begin
                        k_q     <= eng_k;
                        state_q <= UPDATE;
                    end else if (timer_q == TIMER_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                UPDATE: begin
                    if (k_q > best_k_q) begin
                        best_k_q  <= k_q;
                        best_co_q <= cur_q;
                    end
                    // Compare before incrementing so hi = all-ones cannot wrap.
                    if (cur_q == hi_q) begin
                        state_q <= FINISH;
                    end else begin
                        cur_q   <= cur_q + 1'b1;
                        state_q <= LAUNCH;
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign eng_co  = eng_co_q;
    assign eng_st  = eng_st_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign best_co = best_co_q;
    assign best_k  = best_k_q;
    assign cur     = cur_q;

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Directed bench for collatz_sweep_ctrl with a behavioural engine stub.
`timescale 1ns/1ps
module tb_collatz_sweep_ctrl;

    localparam int W_CO    = 16;
    localparam int W_K     = 20;
    localparam int TIMEOUT = 8;
    localparam int MAX_CYC = 2000;

    // Stub modes: real Collatz step count, constant k=7, never respond.
    localparam int M_REAL   = 0;
    localparam int M_TIE    = 1;
    localparam int M_SILENT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            go  = 1'b0;
    logic [W_CO-1:0] lo  = '0;
    logic [W_CO-1:0] hi  = '0;
    logic [W_CO-1:0] eng_co;
    logic            eng_st;
    logic            eng_done;
    logic [W_K-1:0]  eng_k;
    logic            busy;
    logic            done;
    logic            err;
    logic [W_CO-1:0] best_co;
    logic [W_K-1:0]  best_k;
    logic [W_CO-1:0] cur;

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = M_REAL;
    int st_cnt   = 0;
    logic [W_CO-1:0] co_log[$];

    collatz_sweep_ctrl #(.W_CO(W_CO), .W_K(W_K), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .go(go), .lo(lo), .hi(hi),
        .eng_co(eng_co), .eng_st(eng_st), .eng_done(eng_done), .eng_k(eng_k),
        .busy(busy), .done(done), .err(err),
        .best_co(best_co), .best_k(best_k), .cur(cur)
    );

    always #5 clk = ~clk;

    function automatic int collatz_steps(input int n);
        int x = n;
        int k = 0;
        while (x > 1) begin
            x = (x % 2 == 0) ? x / 2 : 3 * x + 1;
            k++;
        end
        return k;
    endfunction

    // Engine stub: answers two cycles after seeing the launch pulse.
    logic [1:0]     stub_cnt;
    logic [W_K-1:0] stub_k;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_cnt <= '0;
            stub_k   <= '0;
            eng_done <= 1'b0;
            eng_k    <= '0;
        end else begin
            eng_done <= 1'b0;
            if (eng_st && mode != M_SILENT) begin
                stub_cnt <= 2'd2;
                stub_k   <= (mode == M_TIE) ? W_K'(7) : W_K'(collatz_steps(int'(eng_co)));
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 2'd1;
                if (stub_cnt == 2'd1) begin
                    eng_done <= 1'b1;
                    eng_k    <= stub_k;
                end
            end
        end
    end

    // Launch monitor: every cycle eng_st is high is logged as one launch.
    always @(posedge clk) begin
        if (!rst && eng_st) begin
            st_cnt <= st_cnt + 1;
            co_log.push_back(eng_co);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Pulse go for one cycle, then count cycles until done (bounded).
    task automatic run_sweep(input logic [W_CO-1:0] l, input logic [W_CO-1:0] h, output int cyc);
        @(negedge clk);
        lo = l;
        hi = h;
        go = 1'b1;
        @(posedge clk);
        #1;
        go  = 1'b0;
        cyc = 0;
        while (!done && cyc < MAX_CYC) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("sweep_terminates", {31'd0, done}, 32'd1);
        $display("sweep lo=%0d hi=%0d cycles=%0d err=%0d best_co=%0d best_k=%0d",
                 l, h, cyc, err, best_co, best_k);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},    {31'd0, busy},    32'd0);
        check_eq({tag, "_done"},    {31'd0, done},    32'd0);
        check_eq({tag, "_err"},     {31'd0, err},     32'd0);
        check_eq({tag, "_eng_st"},  {31'd0, eng_st},  32'd0);
        check_eq({tag, "_eng_co"},  {16'd0, eng_co},  32'd0);
        check_eq({tag, "_best_co"}, {16'd0, best_co}, 32'd0);
        check_eq({tag, "_best_k"},  {12'd0, best_k},  32'd0);
        check_eq({tag, "_cur"},     {16'd0, cur},     32'd0);
    endtask

    initial begin
        int cyc;
        int st_base;
        int log_base;
        int guard;

        // Reset state while reset is held.
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1..10 with real step counts: 9 wins with 19 steps; 6 cycles per value.
        mode     = M_REAL;
        st_base  = st_cnt;
        log_base = co_log.size();
        run_sweep(16'd1, 16'd10, cyc);
        check_eq("r10_cycles",  cyc, 32'd61);
        check_eq("r10_err",     {31'd0, err},  32'd0);
        check_eq("r10_busy",    {31'd0, busy}, 32'd0);
        check_eq("r10_best_co", {16'd0, best_co}, 32'd9);
        check_eq("r10_best_k",  {12'd0, best_k},  32'd19);
        check_eq("r10_cur",     {16'd0, cur},     32'd10);
        check_eq("r10_st_cnt",  st_cnt - st_base, 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (log_base + i < co_log.size())
                check_eq($sformatf("r10_co%0d", i), {16'd0, co_log[log_base + i]}, 32'(i + 1));
            else
                check_eq($sformatf("r10_co%0d_missing", i), 32'd0, 32'd1);
        end

        // Single value 27: 111 steps.
        st_base = st_cnt;
        run_sweep(16'd27, 16'd27, cyc);
        check_eq("r27_cycles",  cyc, 32'd7);
        check_eq("r27_best_co", {16'd0, best_co}, 32'd27);
        check_eq("r27_best_k",  {12'd0, best_k},  32'd111);
        check_eq("r27_st_cnt",  st_cnt - st_base, 32'd1);

        // Bad ranges: straight to FINISH, results cleared, no launch.
        st_base = st_cnt;
        run_sweep(16'd5, 16'd3, cyc);
        check_eq("bad53_cycles", cyc, 32'd1);
        check_eq("bad53_err",    {31'd0, err}, 32'd1);
        check_eq("bad53_best_k", {12'd0, best_k}, 32'd0);
        check_eq("bad53_best_co", {16'd0, best_co}, 32'd0);
        run_sweep(16'd0, 16'd4, cyc);
        check_eq("bad04_cycles", cyc, 32'd1);
        check_eq("bad04_err",    {31'd0, err}, 32'd1);
        check_eq("bad04_best_k", {12'd0, best_k}, 32'd0);
        check_eq("bad_st_cnt",   st_cnt - st_base, 32'd0);

        // Silent engine: 8 WAIT cycles after LAUNCH, then FINISH with err.
        mode    = M_SILENT;
        st_base = st_cnt;
        run_sweep(16'd3, 16'd5, cyc);
        check_eq("to_cycles", cyc, 32'd10);
        check_eq("to_err",    {31'd0, err}, 32'd1);
        check_eq("to_best_k", {12'd0, best_k}, 32'd0);
        check_eq("to_st_cnt", st_cnt - st_base, 32'd1);

        // Equal k for 10 and 11: the earlier value is kept.
        mode = M_TIE;
        run_sweep(16'd10, 16'd11, cyc);
        check_eq("tie_cycles",  cyc, 32'd13);
        check_eq("tie_err",     {31'd0, err}, 32'd0);
        check_eq("tie_best_co", {16'd0, best_co}, 32'd10);
        check_eq("tie_best_k",  {12'd0, best_k},  32'd7);

        // Top of range: one run, no wrap to 0.
        st_base = st_cnt;
        run_sweep(16'hFFFF, 16'hFFFF, cyc);
        check_eq("max_cycles",  cyc, 32'd7);
        check_eq("max_best_co", {16'd0, best_co}, 32'd65535);
        check_eq("max_st_cnt",  st_cnt - st_base, 32'd1);

        // Reset while the fifth launch pulse is out on a 1..100 sweep.
        mode = M_REAL;
        @(negedge clk);
        lo = 16'd1;
        hi = 16'd100;
        go = 1'b1;
        @(posedge clk);
        #1;
        go    = 1'b0;
        guard = 0;
        while (!(eng_st && eng_co == 16'd5) && guard < MAX_CYC) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq("mid_reached_co5", {31'd0, eng_st}, 32'd1);
        check_eq("mid_best_k_pre",  {12'd0, best_k}, 32'd7);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        run_sweep(16'd6, 16'd6, cyc);
        check_eq("post_cycles",  cyc, 32'd7);
        check_eq("post_err",     {31'd0, err}, 32'd0);
        check_eq("post_best_co", {16'd0, best_co}, 32'd6);
        check_eq("post_best_k",  {12'd0, best_k},  32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
